// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// mem_stage_lsu : MEM-stage load/store unit (req/gnt/rvalid data-memory port)
// Optional misaligned-access trap: define LSU_MISALIGN_CHK_EN
// Revision: 1.0
// ============================================================================
module mem_stage_lsu (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_store_data,
   input  logic        flush,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_wstrb,
   output logic [31:0] dm_wdata,
   input  logic        dm_gnt,
   input  logic        dm_rvalid,
   input  logic [31:0] dm_rdata,
   output logic [31:0] load_data,
   output logic        lsu_done,
   output logic        lsu_stall,
   output logic        misalign
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state, state_nx;
   logic        trigger, is_store, accept, mis;
   logic        drain;
   logic [2:0]  funct3_q;
   logic [1:0]  lane_q;
   logic [3:0]  wstrb_c;
   logic [31:0] wdata_c;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] ld_c;

   assign trigger  = ex_valid & (ex_mem_read | ex_mem_write);
   assign is_store = ex_mem_write & ~ex_mem_read;

`ifdef LSU_MISALIGN_CHK_EN
   logic mis_cond;
   always_comb begin
      mis_cond = 1'b0;
      if (ex_funct3 == 3'b010)
         mis_cond = |ex_addr[1:0];
      else if (ex_funct3 == 3'b001 || (ex_mem_read && ex_funct3 == 3'b101))
         mis_cond = ex_addr[0];
   end
   assign mis = (state == IDLE) & trigger & ~flush & mis_cond;
`else
   assign mis = 1'b0;
`endif

   assign misalign = mis;
   assign accept   = (state == IDLE) & trigger & ~flush & ~mis;

   // Store lane steering; halfword/word alignment bits are ignored here
   always_comb begin
      wstrb_c = 4'b1111;
      wdata_c = ex_store_data;
      case (ex_funct3)
         3'b000: begin
            wstrb_c = 4'b0001 << ex_addr[1:0];
            wdata_c = {4{ex_store_data[7:0]}};
         end
         3'b001: begin
            wstrb_c = ex_addr[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{ex_store_data[15:0]}};
         end
         default: begin
            wstrb_c = 4'b1111;
            wdata_c = ex_store_data;
         end
      endcase
   end

   always_comb begin
      byte_v = dm_rdata[7:0];
      case (lane_q)
         2'd0:    byte_v = dm_rdata[7:0];
         2'd1:    byte_v = dm_rdata[15:8];
         2'd2:    byte_v = dm_rdata[23:16];
         default: byte_v = dm_rdata[31:24];
      endcase
      half_v = lane_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
      case (funct3_q)
         3'b000:  ld_c = {{24{byte_v[7]}}, byte_v};
         3'b100:  ld_c = {24'h0, byte_v};
         3'b001:  ld_c = {{16{half_v[15]}}, half_v};
         3'b101:  ld_c = {16'h0, half_v};
         default: ld_c = dm_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // A flush seen in REQ-with-grant or WAIT turns the access into a silent drain
   always_comb begin
      state_nx  = state;
      lsu_stall = 1'b0;
      lsu_done  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nx  = REQ;
               lsu_stall = 1'b1;
            end
         end
         REQ: begin
            lsu_stall = 1'b1;
            if (dm_gnt) begin
               if (!dm_we)     state_nx = WAIT;
               else if (flush) state_nx = IDLE;
               else            state_nx = DONE;
            end else if (flush) begin
               state_nx = IDLE;
            end
         end
         WAIT: begin
            lsu_stall = 1'b1;
            if (dm_rvalid) state_nx = (drain | flush) ? IDLE : DONE;
         end
         DONE: begin
            lsu_done = ~flush;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dm_req    <= 1'b0;
         dm_we     <= 1'b0;
         dm_addr   <= 32'h0;
         dm_wstrb  <= 4'h0;
         dm_wdata  <= 32'h0;
         load_data <= 32'h0;
         funct3_q  <= 3'h0;
         lane_q    <= 2'h0;
         drain     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  dm_req   <= 1'b1;
                  dm_we    <= is_store;
                  dm_addr  <= {ex_addr[31:2], 2'b00};
                  dm_wstrb <= is_store ? wstrb_c : 4'b0000;
                  dm_wdata <= is_store ? wdata_c : 32'h0;
                  funct3_q <= ex_funct3;
                  lane_q   <= ex_addr[1:0];
                  drain    <= 1'b0;
               end
            end
            REQ: begin
               if (dm_gnt || flush) dm_req <= 1'b0;
               if (dm_gnt && flush) drain <= 1'b1;
            end
            WAIT: begin
               if (dm_rvalid) begin
                  if (!(drain || flush)) load_data <= ld_c;
                  drain <= 1'b0;
               end else if (flush) begin
                  drain <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
